seq_divider8: RTL



---
 rtl/seq_divider8_if.sv | 15 +
 rtl/seq_divider8.sv | 108 ++++++++++
 2 files changed

// File: rtl/seq_divider8_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider8.
// The master drives the request; the slave (the divider) returns the result.
interface seq_divider8_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (output start, a, b, input q, r, busy, done, dbz);
  modport slave  (input start, a, b, output q, r, busy, done, dbz);
endinterface

// File: rtl/seq_divider8.sv
// Iterative 8-bit unsigned restoring divider that performs one trial subtraction per cycle.
// Optional macro DIV_ZERO_FLAG_EN: exits early on a zero divisor and raises dbz.
module seq_divider8 (
  input  logic          clk,
  input  logic          rst,
  seq_divider8_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     r_state;
  logic [7:0] r_dq;
  logic [7:0] r_dv;
  logic [7:0] r_pr;
  logic [2:0] r_cnt;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       r_busy;
  logic       r_done;
`ifdef DIV_ZERO_FLAG_EN
  logic       r_dbz;
`endif

  logic [8:0] w_t;
  logic [8:0] w_d;
  logic       w_borrow;
  logic [7:0] w_pr_nx;
  logic [7:0] w_dq_nx;

  // The 9-bit partial remainder always has bit 8 clear once restored (it is below dv),
  // so only its low byte is stored.
  assign w_t      = {r_pr, r_dq[7]};
  assign w_d      = w_t - {1'b0, r_dv};
  assign w_borrow = w_d[8];
  assign w_pr_nx  = w_borrow ? w_t[7:0] : w_d[7:0];
  assign w_dq_nx  = {r_dq[6:0], ~w_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dq    <= '0;
      r_dv    <= '0;
      r_pr    <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      r_dbz   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dq    <= bus.a;
            r_dv    <= bus.b;
            r_pr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef DIV_ZERO_FLAG_EN
            r_dbz   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
`ifdef DIV_ZERO_FLAG_EN
          // dq still holds the untouched dividend on the first RUN edge.
          if (r_cnt == 3'd0 && r_dv == 8'd0) begin
            r_q     <= 8'hFF;
            r_r     <= r_dq;
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else
`endif
          begin
            r_pr  <= w_pr_nx;
            r_dq  <= w_dq_nx;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_q     <= w_dq_nx;
              r_r     <= w_pr_nx;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.dbz  = r_dbz;
`else
  assign bus.dbz  = 1'b0;
`endif
endmodule
